// File: rtl/tdm_pkg.sv
// Shared types and frame geometry for the 4-channel TDM demultiplexer.
// Frame length depends on TDM_DEMUX_PARITY_EN (adds a trailing parity slot).
package tdm_pkg;

    typedef enum logic {
        TDM_HUNT   = 1'b0,
        TDM_LOCKED = 1'b1
    } tdm_state_e;

    localparam int TDM_DATA_SLOTS = 4;

`ifdef TDM_DEMUX_PARITY_EN
    localparam int TDM_NS = TDM_DATA_SLOTS + 1;
`else
    localparam int TDM_NS = TDM_DATA_SLOTS;
`endif

    localparam int TDM_SLOT_W = $clog2(TDM_NS);
    localparam logic [TDM_SLOT_W-1:0] TDM_LAST_SLOT = TDM_SLOT_W'(TDM_NS - 1);

endpackage

// File: rtl/tdm_demux4.sv
// Four-channel TDM demultiplexer with frame-lock tracking and atomic output update.
// Optional even-parity slot enabled by defining TDM_DEMUX_PARITY_EN.
//
// state      | meaning
// TDM_HUNT   | waiting for a beat with fsync to start a frame
// TDM_LOCKED | aligned; collecting slots, expecting fsync at slot 0
module tdm_demux4
    import tdm_pkg::*;
#(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] din,
    input  logic         din_valid,
    input  logic         fsync,
    output logic [W-1:0] out0,
    output logic [W-1:0] out1,
    output logic [W-1:0] out2,
    output logic [W-1:0] out3,
    output logic         frame_valid,
    output logic         locked,
    output logic         parity_err
);

    tdm_state_e            state_q, state_d;
    logic [TDM_SLOT_W-1:0] slot_q, slot_d;
    logic [W-1:0]          sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
    logic [W-1:0]          out0_q, out0_d, out1_q, out1_d, out2_q, out2_d, out3_q, out3_d;
    logic                  frame_valid_q, frame_valid_d;
    logic                  locked_q, locked_d;
`ifdef TDM_DEMUX_PARITY_EN
    logic [W-1:0]          sh3_q, sh3_d;
    logic                  parity_err_q, parity_err_d;
`endif

    always_comb begin
        state_d       = state_q;
        slot_d        = slot_q;
        sh0_d         = sh0_q;
        sh1_d         = sh1_q;
        sh2_d         = sh2_q;
        out0_d        = out0_q;
        out1_d        = out1_q;
        out2_d        = out2_q;
        out3_d        = out3_q;
        frame_valid_d = 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
        sh3_d         = sh3_q;
        parity_err_d  = 1'b0;
`endif
        if (din_valid) begin
            // fsync always restarts the frame, whether hunting, early or on time
            if (fsync) begin
                sh0_d   = din;
                slot_d  = TDM_SLOT_W'(1);
                state_d = TDM_LOCKED;
            end else if (state_q == TDM_LOCKED) begin
                if (slot_q == '0) begin
                    state_d = TDM_HUNT;
                    slot_d  = '0;
                end else if (slot_q == TDM_LAST_SLOT) begin
                    slot_d = '0;
`ifdef TDM_DEMUX_PARITY_EN
                    if ((^{sh0_q, sh1_q, sh2_q, sh3_q}) == din[0]) begin
                        out0_d        = sh0_q;
                        out1_d        = sh1_q;
                        out2_d        = sh2_q;
                        out3_d        = sh3_q;
                        frame_valid_d = 1'b1;
                    end else begin
                        parity_err_d  = 1'b1;
                    end
`else
                    out0_d        = sh0_q;
                    out1_d        = sh1_q;
                    out2_d        = sh2_q;
                    out3_d        = din;
                    frame_valid_d = 1'b1;
`endif
                end else begin
                    if (slot_q == TDM_SLOT_W'(1)) begin
                        sh1_d = din;
                    end else if (slot_q == TDM_SLOT_W'(2)) begin
                        sh2_d = din;
                    end
`ifdef TDM_DEMUX_PARITY_EN
                    else begin
                        sh3_d = din;
                    end
`endif
                    slot_d = slot_q + TDM_SLOT_W'(1);
                end
            end
        end
        locked_d = (state_d == TDM_LOCKED);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= TDM_HUNT;
            slot_q        <= '0;
            sh0_q         <= '0;
            sh1_q         <= '0;
            sh2_q         <= '0;
            out0_q        <= '0;
            out1_q        <= '0;
            out2_q        <= '0;
            out3_q        <= '0;
            frame_valid_q <= 1'b0;
            locked_q      <= 1'b0;
`ifdef TDM_DEMUX_PARITY_EN
            sh3_q         <= '0;
            parity_err_q  <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            slot_q        <= slot_d;
            sh0_q         <= sh0_d;
            sh1_q         <= sh1_d;
            sh2_q         <= sh2_d;
            out0_q        <= out0_d;
            out1_q        <= out1_d;
            out2_q        <= out2_d;
            out3_q        <= out3_d;
            frame_valid_q <= frame_valid_d;
            locked_q      <= locked_d;
`ifdef TDM_DEMUX_PARITY_EN
            sh3_q         <= sh3_d;
            parity_err_q  <= parity_err_d;
`endif
        end
    end

    assign out0        = out0_q;
    assign out1        = out1_q;
    assign out2        = out2_q;
    assign out3        = out3_q;
    assign frame_valid = frame_valid_q;
    assign locked      = locked_q;
`ifdef TDM_DEMUX_PARITY_EN
    assign parity_err  = parity_err_q;
`else
    assign parity_err  = 1'b0;
`endif

endmodule
